dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter LAT, default 2: memory access cycles per transaction, legal range 1-15.
REQ-002 Parameter MEM_BYTES, default 32: size of the byte-addressed data memory being shared.
REQ-003 clk_i  input  1  single clock; every register updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-low.
REQ-005 m0_req_i, m1_req_i  input  1  access request from requester 0 or 1.
REQ-006 m0_we_i, m1_we_i  input  1  1 = word write, 0 = word read.
REQ-007 m0_addr_i, m1_addr_i  input  32  byte address.
REQ-008 m0_wdata_i, m1_wdata_i  input  32  write data.
REQ-009 m0_ack_o, m1_ack_o  output  1  one-cycle completion pulse.
REQ-010 m0_rdata_o, m1_rdata_o  output  32  read data, valid while the matching ack is high.
REQ-011 m0_err_o, m1_err_o  output  1  with ack: access rejected.
REQ-012 mem_addr_o  output  32  address to memory.
REQ-013 mem_wdata_o  output  32  write data to memory.
REQ-014 mem_write_o  output  1  memory write strobe.
REQ-015 mem_read_o  output  1  memory read enable.
REQ-016 mem_rdata_i  input  32  memory read data, combinational from mem_addr_o.
REQ-017 busy_o  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; encoding is free.
REQ-019 IDLE transitions: no req -> IDLE; any req -> latch winner's we, addr and wdata, then go to ACCESS, or go to RESP with error if the address is illegal.
REQ-020 An address is illegal when addr[1:0] != 0 or addr > MEM_BYTES-4.
REQ-021 An illegal access produces no memory strobes.
REQ-022 Arbitration when both requesters are active: round-robin, the requester not granted last wins; a single requester wins immediately.
REQ-023 The round-robin pointer updates only in RESP.
REQ-024 ACCESS holds mem_addr_o and mem_wdata_o from the latched values for exactly LAT cycles, counted by a 4-bit counter.
REQ-025 mem_write_o is high only in the first ACCESS cycle of a write.
REQ-026 mem_read_o is high in all ACCESS cycles of a read.
REQ-027 On the last ACCESS cycle of a read, mem_rdata_i is captured into the granted port's rdata register.
REQ-028 RESP lasts one cycle: the granted port's ack_o is high and err_o is set as applicable, then the FSM returns to IDLE.
REQ-029 Latency: a request sampled in IDLE at edge k gets ack_o high in the cycle after edge k+LAT+1.
REQ-030 An illegal request gets ack_o high in the cycle after edge k+1.
REQ-031 The next grant can be taken at the edge ending RESP+1, i.e. one IDLE cycle minimum between transactions.
REQ-032 Requesters hold req and operands stable until ack; changes during busy_o are ignored.
REQ-033 A requester that drops req before ack still completes; its ack pulse is emitted and must be ignored.
REQ-034 rdata_o holds its value until the next read completes on that port.
REQ-035 The ack outputs are never both high in the same cycle.

Reset
REQ-036 While rst_i=0 at an edge: state goes to IDLE, the counter to 0, the round-robin pointer to "port 1 last" (so port 0 wins the first tie).
REQ-037 Also while rst_i=0: all ack, err and mem strobes go to 0, and rdata_o and mem_addr_o/mem_wdata_o go to 0.
REQ-038 A reset during ACCESS aborts the transaction with no ack; a write already strobed is not undone.

Configuration
REQ-039 Macro DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins simultaneous requests, and the pointer logic is removed.
REQ-040 Macro DMEM_ARB_FIXED_PRIO_EN undefined: round-robin arbitration per REQ-022.

Verification
REQ-041 LAT=2, m0 writes 0xDEADBEEF at addr 8 -> mem_write_o is a single pulse with mem_addr_o=8; m0_ack_o rises 3 edges after the request is sampled.
REQ-042 m1 reads addr 8 after REQ-041 -> m1_rdata_o=0xDEADBEEF with m1_ack_o; mem_read_o is high for 2 cycles.
REQ-043 Both requesters hold reads continuously from reset -> grants go m0, m1, m0, m1; with DMEM_ARB_FIXED_PRIO_EN, grants go m0, m0, m0.
REQ-044 m0 reads addr 6 and addr 32 -> each gets ack with m0_err_o=1 one cycle after RESP entry; mem_read_o and mem_write_o stay 0.
REQ-045 rst_i=0 during the second ACCESS cycle -> no ack, IDLE next cycle, busy_o=0, next tie granted to m0.
REQ-046 Continuous random traffic for 10k cycles -> a scoreboard memory model matches all read data, and the two acks are never high together.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two requesters share one word-wide data memory through an IDLE/ACCESS/RESP FSM.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins ties (default build: round-robin).
module dmem_arbiter #(
   parameter int unsigned LAT       = 2,
   parameter int unsigned MEM_BYTES = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_ack_o,
   output logic [31:0] m0_rdata_o,
   output logic        m0_err_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_ack_o,
   output logic [31:0] m1_rdata_o,
   output logic        m1_err_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_write_o,
   output logic        mem_read_o,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   localparam logic [3:0]  LAST_BEAT = 4'(LAT - 1);
   localparam logic [31:0] MAX_ADDR  = 32'(MEM_BYTES - 4);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  cnt_q;
   logic        gnt_q;
   logic        we_q;
   logic        bad_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata0_q;
   logic [31:0] rdata1_q;
   logic        ack0_q;
   logic        ack1_q;
   logic        err0_q;
   logic        err1_q;

   logic        any_req;
   logic        pick;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_bad;
   logic        last_beat;

   assign any_req = m0_req_i | m1_req_i;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   assign pick = ~m0_req_i;
`else
   // last_q remembers the port that completed most recently; it loses the next tie.
   logic last_q;

   assign pick = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         last_q <= 1'b1;
      end else if (state_q == RESP) begin
         last_q <= gnt_q;
      end
   end
`endif

   assign sel_we    = pick ? m1_we_i    : m0_we_i;
   assign sel_addr  = pick ? m1_addr_i  : m0_addr_i;
   assign sel_wdata = pick ? m1_wdata_i : m0_wdata_i;
   assign sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
   assign last_beat = (cnt_q == LAST_BEAT);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      busy_o      = 1'b1;
      mem_write_o = 1'b0;
      mem_read_o  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_o = 1'b0;
            if (any_req) begin
               state_d = sel_bad ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            mem_write_o = we_q && (cnt_q == 4'd0);
            mem_read_o  = !we_q;
            if (last_beat) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath: operand latch, beat counter, read capture and the registered ack/err pulses.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_q    <= 4'd0;
         gnt_q    <= 1'b0;
         we_q     <= 1'b0;
         bad_q    <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata0_q <= 32'h0;
         rdata1_q <= 32'h0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         err0_q <= 1'b0;
         err1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  gnt_q   <= pick;
                  we_q    <= sel_we;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  bad_q   <= sel_bad;
                  cnt_q   <= 4'd0;
               end
            end
            ACCESS: begin
               if (last_beat) begin
                  cnt_q <= 4'd0;
                  if (!we_q) begin
                     if (gnt_q) begin
                        rdata1_q <= mem_rdata_i;
                     end else begin
                        rdata0_q <= mem_rdata_i;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            RESP: begin
               // The pulse is registered, so it appears in the cycle after RESP.
               if (gnt_q) begin
                  ack1_q <= 1'b1;
                  err1_q <= bad_q;
               end else begin
                  ack0_q <= 1'b1;
                  err0_q <= bad_q;
               end
            end
            default: begin
               cnt_q <= 4'd0;
            end
         endcase
      end
   end

   assign m0_ack_o    = ack0_q;
   assign m1_ack_o    = ack1_q;
   assign m0_err_o    = err0_q;
   assign m1_err_o    = err1_q;
   assign m0_rdata_o  = rdata0_q;
   assign m1_rdata_o  = rdata1_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic against a transaction-level model of dmem_arbiter.
// The model predicts grants from timing arithmetic and keeps its own copy of the memory contents.
module tb_dmem_arbiter;

   localparam int unsigned LAT       = 2;
   localparam int unsigned MEM_BYTES = 32;
   localparam int          WORDS     = MEM_BYTES / 4;
   localparam int          AW        = $clog2(MEM_BYTES);

   logic        clk = 1'b0;
   logic        rst_i;
   logic        m0_req, m0_we, m0_ack, m0_err;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_ack, m1_err;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_write, mem_read, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int edges = 0;

   dmem_arbiter #(.LAT(LAT), .MEM_BYTES(MEM_BYTES)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .m0_req_i   (m0_req),
      .m0_we_i    (m0_we),
      .m0_addr_i  (m0_addr),
      .m0_wdata_i (m0_wdata),
      .m0_ack_o   (m0_ack),
      .m0_rdata_o (m0_rdata),
      .m0_err_o   (m0_err),
      .m1_req_i   (m1_req),
      .m1_we_i    (m1_we),
      .m1_addr_i  (m1_addr),
      .m1_wdata_i (m1_wdata),
      .m1_ack_o   (m1_ack),
      .m1_rdata_o (m1_rdata),
      .m1_err_o   (m1_err),
      .mem_addr_o (mem_addr),
      .mem_wdata_o(mem_wdata),
      .mem_write_o(mem_write),
      .mem_read_o (mem_read),
      .mem_rdata_i(mem_rdata),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (edge %0d)", name, act, exp, edges);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, want %b (edge %0d)", name, act, exp, edges);
      end
   endtask

   // Memory attached to the DUT: combinational read, write on the strobe.
   logic [31:0] mem [WORDS] = '{default: 32'h0};
   assign mem_rdata = (mem_addr < 32'(MEM_BYTES)) ? mem[mem_addr[AW-1:2]] : 32'h0;
   always @(posedge clk) begin
      if (mem_write && mem_addr < 32'(MEM_BYTES)) mem[mem_addr[AW-1:2]] <= mem_wdata;
   end

   // Reference model: one transaction at a time, described by its grant edge.
   typedef struct {
      bit          valid;
      int          g;
      bit          port;
      bit          we;
      bit          legal;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   txn_t        cur;
   bit          last_port;
   bit          g_port;
   int          free_edge = 0;
   logic [31:0] ref_mem [WORDS] = '{default: 32'h0};
   logic [31:0] last_rd [2];

   // Edges from grant to the ack-producing edge.
   function automatic int done_d(input bit legal);
      return legal ? int'(LAT) + 1 : 1;
   endfunction

   always @(posedge clk) begin
      edges++;
      if (!rst_i) begin
         cur.valid  = 1'b0;
         last_port  = 1'b1;
         free_edge  = edges + 1;
         last_rd[0] = 32'h0;
         last_rd[1] = 32'h0;
      end else begin
         if (cur.valid && edges - cur.g == done_d(cur.legal)) last_port = cur.port;
         if (edges >= free_edge && (m0_req || m1_req)) begin
            if (!m1_req) g_port = 1'b0;
            else if (!m0_req) g_port = 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
            else g_port = 1'b0;
`else
            else g_port = (last_port == 1'b0);
`endif
            cur.valid = 1'b1;
            cur.g     = edges;
            cur.port  = g_port;
            cur.we    = g_port ? m1_we : m0_we;
            cur.addr  = g_port ? m1_addr : m0_addr;
            cur.wdata = g_port ? m1_wdata : m0_wdata;
            cur.legal = (cur.addr % 4 == 0) && (longint'(cur.addr) + 4 <= longint'(MEM_BYTES));
            if (cur.legal && cur.we) ref_mem[int'(cur.addr >> 2)] = cur.wdata;
            if (cur.legal && !cur.we) last_rd[g_port] = ref_mem[int'(cur.addr >> 2)];
            cur.rdata = last_rd[g_port];
            free_edge = edges + done_d(cur.legal) + 1;
         end
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge.
   int  d;
   bit  e_busy, e_rd, e_wr, e_ack;
   int  wr_pulses = 0;
   int  rd_cycles = 0;
   logic [31:0] wr_addr_seen = 32'h0;

   always @(negedge clk) begin
      if (edges >= 1) begin
         d      = cur.valid ? edges - cur.g : -1;
         e_busy = cur.valid && d <= (cur.legal ? int'(LAT) : 0);
         e_rd   = cur.valid && cur.legal && !cur.we && d < int'(LAT);
         e_wr   = cur.valid && cur.legal && cur.we && d == 0;
         e_ack  = cur.valid && d == done_d(cur.legal);
         if (mem_write) begin
            wr_pulses++;
            wr_addr_seen = mem_addr;
         end
         if (mem_read) rd_cycles++;
         check_b("busy", busy, e_busy);
         check_b("mem_read", mem_read, e_rd);
         check_b("mem_write", mem_write, e_wr);
         check_b("ack0", m0_ack, e_ack && !cur.port);
         check_b("ack1", m1_ack, e_ack && cur.port);
         check_b("err0", m0_err, e_ack && !cur.port && !cur.legal);
         check_b("err1", m1_err, e_ack && cur.port && !cur.legal);
         check_b("ack_excl", m0_ack && m1_ack, 1'b0);
         if (e_rd || e_wr) check("mem_addr", mem_addr, cur.addr);
         if (e_wr) check("mem_wdata", mem_wdata, cur.wdata);
         if (e_ack && !cur.port) check("rdata0", m0_rdata, cur.rdata);
         if (e_ack && cur.port) check("rdata1", m1_rdata, cur.rdata);
      end
   end

   task automatic drive(input bit p, input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
      if (!p) begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   // Called on a falling edge; returns on the falling edge inside the ack cycle.
   task automatic do_req(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit drop_early, output int lat, output logic [31:0] rd, output logic er);
      int  k;
      bit  got;
      drive(p, 1'b1, we, addr, wdata);
      k   = edges + 1;
      got = 1'b0;
      lat = -1;
      rd  = 32'h0;
      er  = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (drop_early && i == 0) drive(p, 1'b0, we, addr, wdata);
         if (p ? m1_ack : m0_ack) begin
            got = 1'b1;
            lat = edges - k;
            rd  = p ? m1_rdata : m0_rdata;
            er  = p ? m1_err : m0_err;
            drive(p, 1'b0, we, addr, wdata);
         end
      end
      if (!got) check_b("ack_timeout", 1'b0, 1'b1);
   endtask

   function automatic logic [31:0] rand_addr();
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 7) return 32'($urandom_range(0, WORDS - 1) * 4);
      else if (sel == 7) return 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3));
      else if (sel == 8) return 32'(MEM_BYTES + $urandom_range(0, 7) * 4);
      else return $urandom;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   int          lat;
   logic [31:0] rd;
   logic        er;
   int          wr0, rd0, n_ord, n_ack;
   int          order [4];
   logic [3:0]  exp_order;

   initial begin
      rst_i = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      check_b("rst_busy", busy, 1'b0);
      check_b("rst_ack0", m0_ack, 1'b0);
      check_b("rst_ack1", m1_ack, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_rdata0", m0_rdata, 32'h0);
      check("rst_rdata1", m1_rdata, 32'h0);
      rst_i = 1'b1;

      // m0 writes 0xDEADBEEF at 8
      wr0 = wr_pulses;
      do_req(1'b0, 1'b1, 32'd8, 32'hDEADBEEF, 1'b0, lat, rd, er);
      check("wr_latency", 32'(lat), 32'd3);
      check("wr_pulses", 32'(wr_pulses - wr0), 32'd1);
      check("wr_addr", wr_addr_seen, 32'd8);
      check_b("wr_err", er, 1'b0);

      // m1 reads it back
      rd0 = rd_cycles;
      do_req(1'b1, 1'b0, 32'd8, 32'h0, 1'b0, lat, rd, er);
      check("rd_data", rd, 32'hDEADBEEF);
      check("rd_cycles", 32'(rd_cycles - rd0), 32'd2);
      check("rd_latency", 32'(lat), 32'd3);

      // Illegal addresses: unaligned and past the end
      wr0 = wr_pulses;
      rd0 = rd_cycles;
      do_req(1'b0, 1'b0, 32'd6, 32'h0, 1'b0, lat, rd, er);
      check_b("ill6_err", er, 1'b1);
      check("ill6_latency", 32'(lat), 32'd1);
      do_req(1'b0, 1'b0, 32'd32, 32'h0, 1'b0, lat, rd, er);
      check_b("ill32_err", er, 1'b1);
      check("ill32_latency", 32'(lat), 32'd1);
      check("ill_strobes", 32'((wr_pulses - wr0) + (rd_cycles - rd0)), 32'd0);

      // Requester drops req right after its grant; the ack still comes
      do_req(1'b0, 1'b1, 32'd4, 32'h12345678, 1'b1, lat, rd, er);
      check("drop_latency", 32'(lat), 32'd3);

      // Both hold reads continuously from reset
      rst_i = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
      @(negedge clk);
      rst_i = 1'b1;
      n_ord = 0;
      for (int i = 0; i < 60 && n_ord < 4; i++) begin
         @(negedge clk);
         if (m0_ack && n_ord < 4) begin order[n_ord] = 0; n_ord++; end
         if (m1_ack && n_ord < 4) begin order[n_ord] = 1; n_ord++; end
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
      check("grant_count", 32'(n_ord), 32'd4);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_order = 4'b0000;
`else
      exp_order = 4'b1010;
`endif
      for (int i = 0; i < 4; i++) check_b("grant_order", order[i] == 1, exp_order[i]);
      repeat (6) @(negedge clk);

      // Reset in the second ACCESS cycle after m0 was the last one served
      do_req(1'b0, 1'b0, 32'd4, 32'h0, 1'b0, lat, rd, er);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h0);
      @(negedge clk);
      check_b("abort_busy_access", busy, 1'b1);
      @(negedge clk);
      rst_i = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
      @(negedge clk);
      rst_i = 1'b1;
      check_b("abort_busy", busy, 1'b0);
      n_ack = 0;
      for (int i = 0; i < 5; i++) begin
         if (m0_ack || m1_ack) n_ack++;
         @(negedge clk);
      end
      check("abort_no_ack", 32'(n_ack), 32'd0);
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
      n_ord = 0;
      for (int i = 0; i < 20 && n_ord == 0; i++) begin
         @(negedge clk);
         if (m0_ack) begin order[0] = 0; n_ord = 1; end
         else if (m1_ack) begin order[0] = 1; n_ord = 1; end
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
      check("abort_tie_seen", 32'(n_ord), 32'd1);
      check_b("abort_tie_m0", order[0] == 0, 1'b1);
      repeat (6) @(negedge clk);

      // Random traffic: each requester holds its operands until its ack
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         if (m0_req && m0_ack) m0_req = 1'b0;
         if (m1_req && m1_ack) m1_req = 1'b0;
         if (!m0_req && $urandom_range(0, 2) == 0)
            drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
         if (!m1_req && $urandom_range(0, 2) == 0)
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (m0_ack) m0_req = 1'b0;
         if (m1_ack) m1_req = 1'b0;
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
      repeat (8) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
